// File: rtl/approx_prod_accum_if.sv
// Handshake bundle between the approximate multiplier, the product accumulator
// and its result consumer.
//   in_valid/in_ready/in_prod/in_last      : product stream into the accumulator
//   out_valid/out_ready/out_sum/out_cnt/out_ovf : held vector result
// master : producer + consumer side (drives beats, takes results)
// slave  : accumulator side
interface approx_prod_accum_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [7:0]        out_cnt;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/approx_prod_accum.sv
// Streaming saturating accumulator for the 8x8 approximate multiplier products.
// Sums up to LEN unsigned products per vector into an ACC_W-bit saturating sum;
// a vector closes on in_last or on the LEN-th accepted beat. The result is held
// with out_valid until the consumer asserts out_ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (discards any partial vector)
//   clr  : synchronous abort; drops partial sum, any same-cycle beat and any held result
//   bus  : approx_prod_accum_if.slave
//          in_valid/in_ready/in_prod/in_last     product stream
//          out_valid/out_ready/out_sum/out_cnt/out_ovf  held vector result
module approx_prod_accum #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  approx_prod_accum_if.slave bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LEN_CNT = 8'(LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [7:0]       ocnt_q, ocnt_d;
  logic             oovf_q, oovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] acc_new;
  logic             ovf_new;
  logic [7:0]       cnt_new;
  logic             close_vec;

  always_comb begin
    // One extra bit of headroom: the carry out is exactly the saturation condition.
    nxt       = {1'b0, acc_q} + (ACC_W+1)'(bus.in_prod);
    acc_new   = nxt[ACC_W] ? '1 : nxt[ACC_W-1:0];
    ovf_new   = ovf_q | nxt[ACC_W];
    cnt_new   = cnt_q + 8'd1;
    close_vec = bus.in_last | (cnt_new == LEN_CNT);

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    ocnt_d      = ocnt_q;
    oovf_d      = oovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid) begin
            if (close_vec) begin
              sum_d       = acc_new;
              ocnt_d      = cnt_new;
              oovf_d      = ovf_new;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = HOLD;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              acc_d = acc_new;
              cnt_d = cnt_new;
              ovf_d = ovf_new;
            end
          end
        end
        HOLD: begin
          // Result regs are left untouched on handoff; only out_valid drops.
          if (bus.out_ready) begin
            state_d     = ACCUM;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      ocnt_q      <= '0;
      oovf_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      ocnt_q      <= ocnt_d;
      oovf_q      <= oovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cnt   = ocnt_q;
  assign bus.out_ovf   = oovf_q;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Bench for approx_prod_accum: two instances share one stimulus stream, one with a
// 24-bit accumulator and one with a 16-bit accumulator so saturation is exercised
// alongside the wide result. Expected results come from a plain-arithmetic model.
module tb_approx_prod_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  approx_prod_accum_if #(.PROD_W(16), .ACC_W(24)) m_if ();
  approx_prod_accum_if #(.PROD_W(16), .ACC_W(16)) s_if ();

  assign m_if.in_valid  = in_valid;
  assign m_if.in_prod   = in_prod;
  assign m_if.in_last   = in_last;
  assign m_if.out_ready = out_ready;
  assign s_if.in_valid  = in_valid;
  assign s_if.in_prod   = in_prod;
  assign s_if.in_last   = in_last;
  assign s_if.out_ready = out_ready;

  approx_prod_accum #(.PROD_W(16), .ACC_W(24), .LEN(8)) u_main (
    .clk(clk), .rst(rst), .clr(clr), .bus(m_if)
  );

  approx_prod_accum #(.PROD_W(16), .ACC_W(16), .LEN(8)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .bus(s_if)
  );

  // Packed {ovf, cnt[7:0], sum[23:0]} of the saturating sum of a vector.
  function automatic logic [32:0] model(input int unsigned p[$], input int accw);
    longint      t;
    longint      mx;
    logic [32:0] r;
    t = 0;
    foreach (p[i]) t += longint'(p[i]);
    mx = (longint'(1) << accw) - 1;
    r[32]    = (t > mx);
    r[31:24] = 8'(p.size());
    r[23:0]  = (t > mx) ? 24'(mx) : 24'(t);
    return r;
  endfunction

  function automatic logic [32:0] got_main();
    return {m_if.out_ovf, m_if.out_cnt, m_if.out_sum};
  endfunction

  function automatic logic [32:0] got_sat();
    return {s_if.out_ovf, s_if.out_cnt, 8'h00, s_if.out_sum};
  endfunction

  task automatic put_beat(input logic [15:0] p, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    while (m_if.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
      stalls++;
    end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL beat_timeout in_ready=%b required=1", m_if.in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input int unsigned p[$], input bit use_last);
    foreach (p[i]) put_beat(16'(p[i]), use_last && (i == p.size() - 1));
  endtask

  task automatic wait_result();
    int n = 0;
    while (!(m_if.out_valid === 1'b1 && s_if.out_valid === 1'b1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL result_timeout out_valid=%b/%b required=1/1", m_if.out_valid, s_if.out_valid);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned q[$];
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({m_if.in_ready, m_if.out_valid, got_main()} !== {1'b1, 1'b0, 33'd0}) begin
      n_err++;
      $display("FAIL reset_state got=%h required=%h", {m_if.in_ready, m_if.out_valid, got_main()},
               {1'b1, 1'b0, 33'd0});
    end
    rst = 1'b0;
    q = '{1, 1, 1};
    send_vec(q, 1'b0);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({m_if.in_ready, m_if.out_valid, s_if.in_ready, s_if.out_valid} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_mid_vector rdy/vld got=%b required=1010",
               {m_if.in_ready, m_if.out_valid, s_if.in_ready, s_if.out_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_vec(q, 1'b0);
    wait_result();
    n_cmp++;
    if (got_main() !== model(q, 24)) begin
      n_err++;
      $display("FAIL reset_next_vector got=%h required=%h", got_main(), model(q, 24));
    end
    take();
  endtask

  task automatic test_full_vector();
    int unsigned q[$];
    q = '{1, 2, 3, 4, 5, 6, 7, 8};
    stalls = 0;
    send_vec(q, 1'b0);
    n_cmp++;
    if (m_if.out_valid !== 1'b1 || m_if.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_latency out_valid=%b in_ready=%b required=1/0", m_if.out_valid, m_if.in_ready);
    end
    n_cmp++;
    if (stalls !== 0) begin
      n_err++;
      $display("FAIL full_throughput stalls=%0d required=0", stalls);
    end
    wait_result();
    n_cmp++;
    if (got_main() !== {1'b0, 8'd8, 24'd36}) begin
      n_err++;
      $display("FAIL full_sum got=%h required=%h", got_main(), {1'b0, 8'd8, 24'd36});
    end
    take();
    n_cmp++;
    if ({m_if.out_valid, m_if.in_ready, got_main()} !== {1'b0, 1'b1, 1'b0, 8'd8, 24'd36}) begin
      n_err++;
      $display("FAIL full_handoff got=%h required=%h", {m_if.out_valid, m_if.in_ready, got_main()},
               {1'b0, 1'b1, 1'b0, 8'd8, 24'd36});
    end
  endtask

  task automatic test_early_last();
    int unsigned q[$];
    q = '{100, 200};
    send_vec(q, 1'b1);
    wait_result();
    n_cmp++;
    if (got_main() !== model(q, 24) || got_main() !== {1'b0, 8'd2, 24'd300}) begin
      n_err++;
      $display("FAIL early_last got=%h required=%h", got_main(), model(q, 24));
    end
    take();
  endtask

  task automatic test_saturation();
    int unsigned q[$];
    q = '{32'hFFFF, 1, 5};
    send_vec(q, 1'b1);
    wait_result();
    n_cmp++;
    if (got_sat() !== {1'b1, 8'd3, 24'h00FFFF}) begin
      n_err++;
      $display("FAIL sat_narrow got=%h required=%h", got_sat(), {1'b1, 8'd3, 24'h00FFFF});
    end
    n_cmp++;
    if (got_main() !== model(q, 24)) begin
      n_err++;
      $display("FAIL sat_wide got=%h required=%h", got_main(), model(q, 24));
    end
    take();
  endtask

  task automatic test_backpressure();
    int unsigned q[$];
    int unsigned q2[$];
    logic [32:0] snap;
    q = '{};
    repeat (5) q.push_back($urandom_range(0, 65535));
    send_vec(q, 1'b1);
    wait_result();
    snap = got_main();
    in_valid = 1'b1;
    in_prod  = 16'h0007;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({m_if.in_ready, m_if.out_valid} !== 2'b01 || got_main() !== snap) begin
        n_err++;
        $display("FAIL bp_hold c=%0d rdy/vld=%b%b res=%h required=01 %h", c,
                 m_if.in_ready, m_if.out_valid, got_main(), snap);
      end
    end
    n_cmp++;
    if (snap !== model(q, 24)) begin
      n_err++;
      $display("FAIL bp_result got=%h required=%h", snap, model(q, 24));
    end
    take();
    q2 = '{7};
    q2.push_back($urandom_range(0, 65535));
    q2.push_back($urandom_range(0, 65535));
    send_vec(q2, 1'b1);
    wait_result();
    n_cmp++;
    if (got_main() !== model(q2, 24) || got_sat() !== model(q2, 16)) begin
      n_err++;
      $display("FAIL bp_next got=%h/%h required=%h/%h", got_main(), got_sat(), model(q2, 24), model(q2, 16));
    end
    take();
  endtask

  task automatic test_clr();
    int unsigned q[$];
    q = '{1, 1, 1, 1};
    send_vec(q, 1'b0);
    in_valid = 1'b1;
    in_prod  = 16'h0010;
    clr      = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({m_if.in_ready, m_if.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL clr_state rdy/vld=%b%b required=10", m_if.in_ready, m_if.out_valid);
    end
    q = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_vec(q, 1'b0);
    wait_result();
    n_cmp++;
    if (got_main() !== {1'b0, 8'd8, 24'd8}) begin
      n_err++;
      $display("FAIL clr_next got=%h required=%h", got_main(), {1'b0, 8'd8, 24'd8});
    end
    // Abort while a result is held.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_cmp++;
    if ({m_if.in_ready, m_if.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL clr_hold rdy/vld=%b%b required=10", m_if.in_ready, m_if.out_valid);
    end
    q = '{9};
    send_vec(q, 1'b1);
    wait_result();
    n_cmp++;
    if (got_main() !== model(q, 24)) begin
      n_err++;
      $display("FAIL clr_after_hold got=%h required=%h", got_main(), model(q, 24));
    end
    take();
  endtask

  task automatic test_back_to_back();
    int unsigned q[$];
    int unsigned len;
    bit          use_last;
    for (int v = 0; v < 30; v++) begin
      len = $urandom_range(1, 8);
      q = '{};
      for (int unsigned b = 0; b < len; b++)
        q.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 255));
      use_last = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      send_vec(q, use_last);
      wait_result();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      n_cmp++;
      if (got_main() !== model(q, 24) || got_sat() !== model(q, 16)) begin
        n_err++;
        $display("FAIL random v=%0d got=%h/%h required=%h/%h", v, got_main(), got_sat(),
                 model(q, 24), model(q, 16));
      end
      take();
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_early_last();
    test_saturation();
    test_backpressure();
    test_clr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
